// File: rtl/m_len_block_framer_pkg.sv
// Shared definitions for the block framer and its neighbours.
// The length width matches the upstream link-ID length encoder.
package m_len_block_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } frm_state_t;

    localparam int LEN_W_DEF = 13;
    localparam int BLK_W_DEF = 8;

endpackage

// File: rtl/m_len_out_reg.sv
// Single-entry output register carrying {bit, sof, eof, pad}.
// It loads only when the slot is free and holds its contents while the sink stalls.
module m_len_out_reg (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d_bit,
    input  logic d_sof,
    input  logic d_eof,
    input  logic d_pad,
    input  logic out_ready,
    output logic slot_free,
    output logic out_valid,
    output logic out_bit,
    output logic out_sof,
    output logic out_eof,
    output logic out_pad
);

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_pad   <= 1'b0;
        end else if (load && slot_free) begin
            out_valid <= 1'b1;
            out_bit   <= d_bit;
            out_sof   <= d_sof;
            out_eof   <= d_eof;
            out_pad   <= d_pad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/m_len_block_framer.sv
// Frames a serial bit stream into blocks of m_len bits and zero-pads a short final block.
//   state | meaning
//   IDLE  | waiting for start; the last output bit may still be draining
//   RUN   | accepting source bits and framing them
//   PAD   | source ended early; inserting zero bits up to the block end
module m_len_block_framer
    import m_len_block_framer_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int BLK_W = BLK_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] m_len,
    input  logic             start,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_pad,
    output logic             busy,
    output logic [BLK_W-1:0] blk_cnt,
    output logic             len_err
);

    frm_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             slot_free;
    logic             accept;
    logic             pad_load;
    logic             sof_hit;
    logic             eof_hit;

    assign in_ready = (state == RUN) && slot_free;
    assign accept   = in_valid && in_ready;
    assign pad_load = (state == PAD) && slot_free;
    assign sof_hit  = (cnt == '0);
    // len_q is never zero once latched, so the decrement cannot wrap.
    assign eof_hit  = (cnt == (len_q - LEN_W'(1)));
    assign busy     = (state != IDLE) || out_valid;

    m_len_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept || pad_load),
        .d_bit     (accept ? in_bit : 1'b0),
        .d_sof     (sof_hit),
        .d_eof     (eof_hit),
        .d_pad     (pad_load),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_pad   (out_pad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_q   <= '0;
            cnt     <= '0;
            blk_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (m_len == '0) begin
                            len_err <= 1'b1;
                        end else begin
                            len_q   <= m_len;
                            cnt     <= '0;
                            blk_cnt <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (eof_hit) begin
                            cnt     <= '0;
                            blk_cnt <= blk_cnt + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        if (in_last) begin
                            state <= eof_hit ? IDLE : PAD;
                        end
                    end
                end
                PAD: begin
                    if (slot_free) begin
                        if (eof_hit) begin
                            cnt     <= '0;
                            blk_cnt <= blk_cnt + 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
